timing_fpga_core: RTL and testbench

GPS-disciplined timing block running on the timing-FPGA clock. It keeps a free-running local second counter and emits a top-of-second mark to the DDC, a clean fixed-width PPS, and a slow clock for the microcontroller. It synchronises the raw receiver PPS and issues a TDC stop aligned to the next slow-clock rising edge. All `*_next` outputs lead their event by one cycle so a top-level pad register can align them.

---
 rtl/timing_fpga_pkg.sv | 12 +
 rtl/timing_fpga_core_pps_sync_edge.sv | 12 +
 rtl/timing_fpga_core.sv | 83 ++++++++
 tb/tb_timing_fpga_core.sv | 155 +++++++++++++++
 4 files changed

// File: rtl/timing_fpga_pkg.sv
// timing_fpga_pkg: shared types, count-width helpers and parameter legality checks for timing_fpga_core
package timing_fpga_pkg;
  typedef enum logic {IDLE, PENDING} stop_state_e;
  localparam int DefaultCpsW = $clog2(10000);
  localparam int DefaultSlowW = $clog2(100);
  function automatic int cnt_w(input int n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction
  function automatic bit params_ok(input int cps, input int pps_w, input int slow_p);
    return (pps_w >= 1) && (pps_w < cps) && (slow_p >= 4) && (slow_p % 2 == 0) && (cps % slow_p == 0);
  endfunction
endpackage

// File: rtl/timing_fpga_core_pps_sync_edge.sv
// pps_sync_edge: two-flop synchroniser for an async pulse plus rising-edge detect (clk, rst, d in; rise out, combinational from flops)
module pps_sync_edge (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic rise
);
  logic [2:0] sync_d, sync_q;
  always_comb sync_d = {sync_q[1:0], d};
  always_ff @(posedge clk) sync_q <= rst ? 3'b000 : sync_d;
  assign rise = sync_q[1] & ~sync_q[2];
endmodule

// File: rtl/timing_fpga_core.sv
// timing_fpga_core: second counter, slow clock, PPS/TOS marks and slow-clock-aligned TDC stop (clk_tf, tf_reset, pps_raw_logic in; registered marks out)
module timing_fpga_core
  import timing_fpga_pkg::*;
#(
  parameter int ClocksPerSecond = 10000,
  parameter int PpsPulseWidth = 10,
  parameter int SlowClockPeriod = 100
) (
  input  logic clk_tf,
  input  logic tf_reset,
  input  logic pps_raw_logic,
  output logic tos_mark_ddc,
  output logic tdc_stop_next,
  output logic pps_clean_next,
  output logic uc_slow_clock,
  output logic uc_pps_next,
  output logic uc_stop_next,
  output logic uc_stop_done
);
  localparam int CW = cnt_w(ClocksPerSecond);
  localparam int PW = cnt_w(SlowClockPeriod);
  localparam logic [CW-1:0] CLast = CW'(ClocksPerSecond - 1);
  localparam logic [PW-1:0] PLast = PW'(SlowClockPeriod - 1);
  if (!params_ok(ClocksPerSecond, PpsPulseWidth, SlowClockPeriod)) begin : g_bad_params
    $error("timing_fpga_core: illegal parameter combination");
  end
  logic rise, stop_fire, arm;
  logic [CW-1:0] sec_cnt_d, sec_cnt_q;
  logic [PW-1:0] ph_d, ph_q;
  stop_state_e state_d, state_q;
  logic tos_d, tos_q, stop_d, stop_q, clean_d, clean_q, slow_d, slow_q, upps_d, upps_q, done_d, done_q;
  pps_sync_edge u_sync (
    .clk (clk_tf),
    .rst (tf_reset),
    .d   (pps_raw_logic),
    .rise(rise)
  );
  // Phase counts alongside the second counter; since the period divides the
  // second, both wrap together and ph always equals sec_cnt mod period.
  always_comb begin
    sec_cnt_d = (sec_cnt_q == CLast) ? '0 : sec_cnt_q + 1'b1;
    ph_d = (ph_q == PLast) ? '0 : ph_q + 1'b1;
    stop_fire = (state_q == PENDING) && (ph_q == PLast);
    arm = (state_q == IDLE) && rise;
    state_d = stop_fire ? IDLE : arm ? PENDING : state_q;
    done_d = stop_fire ? 1'b1 : arm ? 1'b0 : done_q;
    stop_d = stop_fire;
    tos_d = (sec_cnt_q == '0);
    clean_d = (sec_cnt_q == CLast) || (int'(sec_cnt_q) <= PpsPulseWidth - 2);
    slow_d = int'(ph_q) < SlowClockPeriod / 2;
    upps_d = (sec_cnt_q == CLast) || (int'(sec_cnt_q) <= SlowClockPeriod - 2);
  end
  always_ff @(posedge clk_tf) begin
    if (tf_reset) begin
      sec_cnt_q <= '0;
      ph_q <= '0;
      state_q <= IDLE;
      tos_q <= 1'b0;
      stop_q <= 1'b0;
      clean_q <= 1'b0;
      slow_q <= 1'b0;
      upps_q <= 1'b0;
      done_q <= 1'b0;
    end else begin
      sec_cnt_q <= sec_cnt_d;
      ph_q <= ph_d;
      state_q <= state_d;
      tos_q <= tos_d;
      stop_q <= stop_d;
      clean_q <= clean_d;
      slow_q <= slow_d;
      upps_q <= upps_d;
      done_q <= done_d;
    end
  end
  assign tos_mark_ddc = tos_q;
  assign tdc_stop_next = stop_q;
  assign uc_stop_next = stop_q;
  assign pps_clean_next = clean_q;
  assign uc_slow_clock = slow_q;
  assign uc_pps_next = upps_q;
  assign uc_stop_done = done_q;
endmodule

// File: tb/tb_timing_fpga_core.sv
// tb_timing_fpga_core: randomized PPS stimulus against a behavioural model with a queue-based scoreboard
module tb_timing_fpga_core;
  localparam int C = 10000;
  localparam int W = 10;
  localparam int P = 100;
  logic clk_tf = 1'b0;
  logic tf_reset = 1'b1;
  logic pps_raw_logic = 1'b0;
  logic tos_mark_ddc, tdc_stop_next, pps_clean_next, uc_slow_clock, uc_pps_next, uc_stop_next, uc_stop_done;
  typedef struct packed {
    logic tos, stop, clean, slow, upps, ustop, done;
  } out_t;
  out_t exp_q[$];
  int m_cnt = 0;
  bit m_pend = 0;
  bit m_done = 0;
  bit hist[$] = '{0, 0, 0};
  int checks = 0;
  int errors = 0;
  timing_fpga_core #(
    .ClocksPerSecond(C),
    .PpsPulseWidth(W),
    .SlowClockPeriod(P)
  ) dut (
    .clk_tf(clk_tf),
    .tf_reset(tf_reset),
    .pps_raw_logic(pps_raw_logic),
    .tos_mark_ddc(tos_mark_ddc),
    .tdc_stop_next(tdc_stop_next),
    .pps_clean_next(pps_clean_next),
    .uc_slow_clock(uc_slow_clock),
    .uc_pps_next(uc_pps_next),
    .uc_stop_next(uc_stop_next),
    .uc_stop_done(uc_stop_done)
  );
  always #50 clk_tf = ~clk_tf;
  // Model: each edge registers the outputs decoded from the count of the cycle
  // being closed; raw PPS reaches the edge detector two samples late.
  always @(posedge clk_tf) begin
    out_t e;
    int ph;
    bit rise;
    e = '0;
    if (tf_reset) begin
      m_cnt = 0;
      m_pend = 0;
      m_done = 0;
      hist = '{0, 0, 0};
    end else begin
      ph = m_cnt % P;
      rise = hist[1] && !hist[0];
      e.tos = (m_cnt == 0);
      e.clean = (m_cnt == C - 1) || (m_cnt <= W - 2);
      e.slow = (ph < P / 2);
      e.upps = (m_cnt == C - 1) || (m_cnt <= P - 2);
      if (m_pend) begin
        if (ph == P - 1) begin
          e.stop = 1;
          m_pend = 0;
          m_done = 1;
        end
      end else if (rise) begin
        m_pend = 1;
        m_done = 0;
      end
      e.ustop = e.stop;
      e.done = m_done;
      hist.push_back(pps_raw_logic);
      void'(hist.pop_front());
      m_cnt = (m_cnt + 1) % C;
    end
    exp_q.push_back(e);
  end
  task automatic chk(input string n, input logic a, input logic b);
    checks++;
    if (a !== b) begin
      errors++;
      $display("FAIL %s at model cnt %0d: got %b, expected %b", n, m_cnt, a, b);
    end
  endtask
  always @(negedge clk_tf) begin
    out_t e;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      chk("tos_mark_ddc", tos_mark_ddc, e.tos);
      chk("tdc_stop_next", tdc_stop_next, e.stop);
      chk("pps_clean_next", pps_clean_next, e.clean);
      chk("uc_slow_clock", uc_slow_clock, e.slow);
      chk("uc_pps_next", uc_pps_next, e.upps);
      chk("uc_stop_next", uc_stop_next, e.ustop);
      chk("uc_stop_done", uc_stop_done, e.done);
    end
  end
  task automatic cyc(input int n);
    repeat (n) @(negedge clk_tf);
  endtask
  task automatic wait_cnt(input int t);
    int b;
    b = 0;
    while (m_cnt != t && b < 2 * C) begin
      @(negedge clk_tf);
      b++;
    end
    checks++;
    if (m_cnt != t) begin
      errors++;
      $display("FAIL wait_cnt: reached %0d, wanted %0d", m_cnt, t);
    end
  endtask
  task automatic pulse(input int w);
    pps_raw_logic = 1'b1;
    cyc(w);
    pps_raw_logic = 1'b0;
  endtask
  initial begin
    tf_reset = 1'b1;
    cyc(10);
    tf_reset = 1'b0;
    wait_cnt(20);
    pulse(2);
    wait_cnt(130);
    pulse(2);
    wait_cnt(297);
    pulse(1);
    wait_cnt(330);
    pulse(3);
    wait_cnt(420);
    pulse(2);
    wait_cnt(460);
    tf_reset = 1'b1;
    cyc(5);
    tf_reset = 1'b0;
    while (m_cnt < 9700) begin
      cyc($urandom_range(20, 400));
      if (m_cnt < 9700) pulse(($urandom_range(0, 7) == 0) ? 150 : $urandom_range(1, 5));
    end
    wait_cnt(9930);
    pulse(2);
    wait_cnt(150);
    repeat (12) begin
      cyc($urandom_range(20, 200));
      pulse($urandom_range(1, 4));
      if ($urandom_range(0, 3) == 0) begin
        cyc($urandom_range(1, 60));
        tf_reset = 1'b1;
        cyc($urandom_range(1, 4));
        tf_reset = 1'b0;
      end
    end
    cyc(300);
    #1;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
